shift_unit: RTL and testbench
=============================

# shift_unit

Parametrised multi-cycle shifter that generalises the fixed shift-left-by-2 block. It supports a variable shift amount, four modes (logical left, logical right, arithmetic right, rotate left) and any power-of-two data width. Each cycle it shifts by up to STEP positions, which trades latency for area. It sits beside the ALU in the multicycle datapath, behind a valid/ready handshake on both sides.

## Interface
- WIDTH, 32: data width in bits; power of two, at least 2.
- STEP, 4: maximum shift positions applied per cycle; 1 ≤ STEP ≤ WIDTH.
- SHAMT_W, $clog2(WIDTH): shift-amount width; derived, not overridden.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request; high only in IDLE.
- op  input  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROL.
- a  input  WIDTH  operand.
- shamt  input  SHAMT_W  shift amount, 0..WIDTH-1.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts the result.
- y  output  WIDTH  result.
- busy  output  1  state is not IDLE.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch a, op and shamt into internal registers (data, mode, remaining).
  - If shamt==0, go to DONE. Otherwise go to SHIFT.
- SHIFT:
  - Each cycle, k = min(remaining, STEP).
  - data is shifted by k according to mode:
    - SLL: zero-fill from the LSB.
    - SRL: zero-fill from the MSB.
    - SRA: fill with data[WIDTH-1]. The sign bit is re-read each step, which is equivalent to the original sign.
    - ROL: bits leaving the MSB enter at the LSB.
  - remaining -= k. When the new remaining is 0, go to DONE.
- DONE:
  - out_valid=1 and y=data.
  - y and out_valid hold stable while out_ready=0.
  - On out_ready=1, go to IDLE.
- y reflects the internal data register at all times. It is only meaningful while out_valid=1.
- in_valid and the input fields are ignored outside IDLE. There is no queuing and no overlap of requests.
- Arithmetic: all shifts are modulo nothing. shamt is strictly less than WIDTH by construction of SHAMT_W, so the result equals the single-step reference shift of a by shamt.
- Reset (reset_n=0, any state, including mid-SHIFT or DONE):
  - State goes to IDLE immediately; the in-flight operation is discarded.
  - data, remaining and mode clear to 0.
  - Outputs: out_valid=0, y=0, busy=0, in_ready=1.

## Timing
- Accept occurs at edge E0 (in_valid&&in_ready sampled high).
- Latency to out_valid:
  - shamt==0: out_valid high after E0+1. Total 1 cycle.
  - shamt>0: ceil(shamt/STEP) SHIFT cycles, then out_valid high after edge E0+ceil(shamt/STEP)+1.
- Result hand-off occurs on the edge where out_valid&&out_ready.
- in_ready rises the cycle after that edge (IDLE). The earliest next accept is one cycle after hand-off.
- Minimum issue interval: latency + 1 cycle with out_ready held high.
- in_ready, out_valid and busy are decoded from the state register only. There are no combinational paths from in_valid or out_ready to any output.
- Reset deassertion: the first accept can occur on the first rising edge with reset_n=1.

## Test plan
- WIDTH=32, STEP=4, SLL, a=0x0000_0001, shamt=2, out_ready=1:
  - y=0x0000_0004, out_valid 2 cycles after accept.
  - Also sweep 256 random a with SLL by 2: y must equal {a[29:0],2'b00}.
- SRA, a=0x8000_0000, shamt=31:
  - y=0xFFFF_FFFF, out_valid after 9 cycles, busy high throughout.
- SRL, a=0xF000_0000, shamt=28:
  - y=0x0000_000F, latency 8.
- ROL, a=0x8000_0001, shamt=4:
  - y=0x0000_0018.
- shamt=0 with any op, a=0xDEAD_BEEF:
  - y=0xDEAD_BEEF after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles in DONE:
  - y and out_valid stay stable and in_ready stays 0.
  - in_valid pulses during SHIFT and DONE are ignored.
- Reset mid-SHIFT (SRA by 31, assert reset_n=0 on the 3rd SHIFT cycle):
  - Immediately out_valid=0, y=0, busy=0, in_ready=1.
  - After release, a new SLL 0x1 by 1 returns 0x2 after 2 cycles.
- Parameter sweep, WIDTH=8 with STEP∈{1,3,8}:
  - All ops and all shamt 0..7 on random a.
  - Results must match the reference model, and latency must equal ceil(shamt/STEP)+1 (1 when shamt=0).

Source files
------------

// File: rtl/shift_unit.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROL by a variable amount, applying at most
// STEP positions per cycle, with valid/ready handshakes on input and output.
module shift_unit #(
    parameter  int WIDTH   = 32,
    parameter  int STEP    = 4,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   y,
    output logic               busy
);

    // remaining never exceeds WIDTH-1, so a step larger than that is never taken
    localparam int KMAX = (STEP < WIDTH) ? STEP : WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_data;
    logic [1:0]         r_mode;
    logic [SHAMT_W-1:0] r_remaining;
    logic [SHAMT_W-1:0] w_k;
    logic [SHAMT_W-1:0] w_rem_next;
    logic [WIDTH-1:0]   w_shifted;
    logic [WIDTH-1:0]   w_cand [KMAX+1];
    logic               w_accept;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_k        = (int'(r_remaining) >= STEP) ? SHAMT_W'(KMAX) : r_remaining;
    assign w_rem_next = r_remaining - w_k;
    assign y          = r_data;

    // One fixed-distance shifter per possible step size; the step mux picks one.
    generate
        for (genvar gi = 0; gi <= KMAX; gi++) begin : g_cand
            logic signed [WIDTH-1:0] w_sra;
            logic        [WIDTH-1:0] w_rol;

            assign w_sra = $signed(r_data) >>> gi;

            if (gi == 0) begin : g_rol0
                assign w_rol = r_data;
            end else begin : g_roln
                assign w_rol = {r_data[WIDTH-1-gi:0], r_data[WIDTH-1:WIDTH-gi]};
            end

            assign w_cand[gi] = (r_mode == 2'b00) ? (r_data << gi) :
                                (r_mode == 2'b01) ? (r_data >> gi) :
                                (r_mode == 2'b10) ? w_sra : w_rol;
        end
    endgenerate

    always_comb begin
        w_shifted = r_data;
        for (int i = 0; i <= KMAX; i++) begin
            if (w_k == SHAMT_W'(i)) begin
                w_shifted = w_cand[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_next = (shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (w_rem_next == '0) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == S_IDLE);
        out_valid = (r_state == S_DONE);
        busy      = (r_state != S_IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data      <= '0;
            r_mode      <= '0;
            r_remaining <= '0;
        end else if (w_accept) begin
            r_data      <= a;
            r_mode      <= op;
            r_remaining <= shamt;
        end else if (r_state == S_SHIFT) begin
            r_data      <= w_shifted;
            r_remaining <= w_rem_next;
        end
    end

endmodule

// File: tb/tb_shift_unit.sv
// Directed-vector bench for shift_unit: a 32-bit/STEP=4 instance plus three
// 8-bit instances with STEP of 1, 3 and 8.
module tb_shift_unit;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  op;
    logic [31:0] a;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] y;
    logic        busy;

    logic        in_valid8  [3];
    logic        in_ready8  [3];
    logic [1:0]  op8        [3];
    logic [7:0]  a8         [3];
    logic [2:0]  sh8        [3];
    logic        out_valid8 [3];
    logic [7:0]  y8         [3];
    logic        busy8      [3];
    logic        out_ready8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    shift_unit #(.WIDTH(32), .STEP(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .shamt(shamt), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .busy(busy)
    );

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_w8
            shift_unit #(.WIDTH(8), .STEP(gi == 0 ? 1 : (gi == 1 ? 3 : 8))) u_dut8 (
                .clk(clk), .reset_n(reset_n), .in_valid(in_valid8[gi]),
                .in_ready(in_ready8[gi]), .op(op8[gi]), .a(a8[gi]), .shamt(sh8[gi]),
                .out_valid(out_valid8[gi]), .out_ready(out_ready8), .y(y8[gi]),
                .busy(busy8[gi])
            );
        end
    endgenerate

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [4:0]  sh;
        logic [31:0] exp_y;
        int          exp_lat;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] ref8(input logic [1:0] o, input logic [7:0] v, input int s);
        logic signed [7:0] sv;
        logic [15:0]       d;
        sv = v;
        d  = {v, v} << s;
        case (o)
            2'b00:   return v << s;
            2'b01:   return v >> s;
            2'b10:   return sv >>> s;
            default: return d[15:8];
        endcase
    endfunction

    // Latency = rising edges from the accept edge (inclusive) to the first edge after which out_valid is seen.
    task automatic run32(input logic [1:0] o, input logic [31:0] av, input logic [4:0] s,
                         output logic [31:0] yv, output int lat, output logic busy_ok);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL run32_in_ready_timeout actual=0 required=1");
        end
        op = o; a = av; shamt = s; in_valid = 1'b1;
        lat = 0; busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid = 1'b0;
            if (!busy || in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 200);
        yv = y;
        if (!out_valid) begin
            checks++; errors++;
            $display("FAIL run32_out_valid_timeout actual=0 required=1");
        end
    endtask

    task automatic run8(input int idx, input logic [1:0] o, input logic [7:0] av, input logic [2:0] s,
                        output logic [7:0] yv, output int lat);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready8[idx] && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready8[idx]) begin
            checks++; errors++;
            $display("FAIL run8_in_ready_timeout inst=%0d actual=0 required=1", idx);
        end
        op8[idx] = o; a8[idx] = av; sh8[idx] = s; in_valid8[idx] = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) in_valid8[idx] = 1'b0;
        end while (!out_valid8[idx] && lat < 100);
        yv = y8[idx];
        if (!out_valid8[idx]) begin
            checks++; errors++;
            $display("FAIL run8_out_valid_timeout inst=%0d actual=0 required=1", idx);
        end
    endtask

    initial begin
        logic [31:0] yv;
        logic [7:0]  yv8;
        logic [31:0] rv;
        logic        bok;
        int          lat;
        int          stp;
        int          w;

        vecs[0]  = '{2'b00, 32'h0000_0001, 5'd2,  32'h0000_0004, 2};
        vecs[1]  = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9};
        vecs[2]  = '{2'b01, 32'hF000_0000, 5'd28, 32'h0000_000F, 8};
        vecs[3]  = '{2'b11, 32'h8000_0001, 5'd4,  32'h0000_0018, 2};
        vecs[4]  = '{2'b00, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[5]  = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[6]  = '{2'b10, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[7]  = '{2'b11, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1};
        vecs[8]  = '{2'b10, 32'h7000_0000, 5'd5,  32'h0380_0000, 3};
        vecs[9]  = '{2'b10, 32'hF000_0000, 5'd4,  32'hFF00_0000, 2};
        vecs[10] = '{2'b11, 32'h1234_5678, 5'd31, 32'h091A_2B3C, 9};
        vecs[11] = '{2'b00, 32'hFFFF_FFFF, 5'd31, 32'h8000_0000, 9};
        vecs[12] = '{2'b01, 32'h8000_0000, 5'd1,  32'h4000_0000, 2};
        vecs[13] = '{2'b11, 32'h0F00_0000, 5'd8,  32'h0000_000F, 3};

        reset_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; shamt = '0; out_ready = 1'b1;
        out_ready8 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_valid8[i] = 1'b0; op8[i] = '0; a8[i] = '0; sh8[i] = '0;
        end

        #12;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_y", y, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run32(vecs[i].op, vecs[i].a, vecs[i].sh, yv, lat, bok);
            $display("vec %0d op=%0d a=%h sh=%0d y=%h lat=%0d", i, vecs[i].op, vecs[i].a, vecs[i].sh, yv, lat);
            chk($sformatf("vec%0d_y", i), yv, vecs[i].exp_y);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("vec%0d_busy", i), 32'(bok), 32'd1);
        end

        for (int i = 0; i < 256; i++) begin
            rv = $urandom;
            run32(2'b00, rv, 5'd2, yv, lat, bok);
            chk($sformatf("sll2_rand%0d_y", i), yv, {rv[29:0], 2'b00});
        end
        $display("sll2 random sweep done, 256 transactions");

        // Backpressure: result held in DONE, junk requests ignored throughout.
        @(negedge clk);
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        out_ready = 1'b0;
        op = 2'b01; a = 32'hF000_0000; shamt = 5'd28; in_valid = 1'b1;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == 1) begin
                a = 32'h1234_5678; op = 2'b00; shamt = 5'd1;
            end
        end while (!out_valid && lat < 200);
        $display("backpressure op y=%h lat=%0d", y, lat);
        chk("bp_lat", 32'(lat), 32'd8);
        chk("bp_y", y, 32'h0000_000F);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            chk($sformatf("bp_hold%0d_y", i), y, 32'h0000_000F);
            chk($sformatf("bp_hold%0d_out_valid", i), 32'(out_valid), 32'd1);
            chk($sformatf("bp_hold%0d_in_ready", i), 32'(in_ready), 32'd0);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_in_ready", 32'(in_ready), 32'd1);
        chk("bp_release_out_valid", 32'(out_valid), 32'd0);
        chk("bp_release_busy", 32'(busy), 32'd0);

        // Asynchronous reset during the third SHIFT cycle.
        @(negedge clk);
        op = 2'b10; a = 32'h8000_0000; shamt = 5'd31; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        $display("reset mid-shift out_valid=%0d y=%h busy=%0d in_ready=%0d", out_valid, y, busy, in_ready);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_y", y, 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        run32(2'b00, 32'h1, 5'd1, yv, lat, bok);
        $display("post-reset SLL 1 by 1 y=%h lat=%0d", yv, lat);
        chk("postrst_y", yv, 32'h2);
        chk("postrst_lat", 32'(lat), 32'd2);

        for (int idx = 0; idx < 3; idx++) begin
            stp = (idx == 0) ? 1 : ((idx == 1) ? 3 : 8);
            for (int o = 0; o < 4; o++) begin
                for (int s = 0; s < 8; s++) begin
                    rv = $urandom;
                    run8(idx, 2'(o), rv[7:0], 3'(s), yv8, lat);
                    $display("w8 step=%0d op=%0d a=%h sh=%0d y=%h lat=%0d", stp, o, rv[7:0], s, yv8, lat);
                    chk($sformatf("w8_s%0d_op%0d_sh%0d_y", stp, o, s), 32'(yv8),
                        32'(ref8(2'(o), rv[7:0], s)));
                    chk($sformatf("w8_s%0d_op%0d_sh%0d_lat", stp, o, s), 32'(lat),
                        32'((s + stp - 1) / stp + 1));
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
